// File: rtl/dircc_avalon_st_packet_receiver.sv
// dircc_avalon_st_packet_receiver: reassembles 8-beat Avalon-ST DiRCC packets into packet_t
// behind a one-entry output buffer, dropping malformed packets with an error pulse.
package dircc_types_pkg;

    typedef struct packed {
        logic [31:0] hw_addr;
        logic [15:0] sw_addr;
        logic [6:0]  port;
        logic        flag;
    } address_t;

    typedef struct packed {
        address_t    dest_addr;
        address_t    src_addr;
        logic [31:0] lamport;
        logic [95:0] data;
    } packet_t;

endpackage

module dircc_avalon_st_packet_receiver
    import dircc_types_pkg::*;
#(
    parameter int BITS_PER_SYMBOL = 8,
    parameter int SYMBOLS_PER_BEAT = 4,
    localparam int DATA_WIDTH = BITS_PER_SYMBOL * SYMBOLS_PER_BEAT,
    localparam int EMPTY_WIDTH = (SYMBOLS_PER_BEAT > 1) ? $clog2(SYMBOLS_PER_BEAT) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [DATA_WIDTH-1:0]  data,
    input  logic [EMPTY_WIDTH-1:0] empty,
    input  logic                   startofpacket,
    input  logic                   endofpacket,
    input  logic                   valid,
    output logic                   ready,
    output logic                   packet_valid,
    output packet_t                packet_data,
    input  logic                   packet_read,
    output logic                   receiving,
    output logic                   error
);

    if (DATA_WIDTH != 32) begin : g_width_check
        $error("dircc_avalon_st_packet_receiver requires DATA_WIDTH == 32");
    end

    typedef enum logic [3:0] {
        WAIT_SOP, DEST0, DEST1, SRC0, SRC1, LAMPORT, DATA0, DATA1, DATA2, DISCARD
    } state_t;

    state_t  state;
    packet_t asm_pkt;
    packet_t commit_pkt;
    logic    bad;
    logic    accept;
    logic    empty_bad;

    // Only the final beat waits for the output buffer; earlier beats always stream.
    assign ready     = (state != DATA2) || !packet_valid || packet_read;
    assign accept    = valid && ready;
    assign empty_bad = |empty;
    assign receiving = state != WAIT_SOP;

    always_comb begin
        commit_pkt = asm_pkt;
        commit_pkt.data[95:64] = data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= WAIT_SOP;
            packet_valid <= 1'b0;
            error        <= 1'b0;
            bad          <= 1'b0;
        end else begin
            error <= 1'b0;
            if (packet_read)
                packet_valid <= 1'b0;
            if (accept) begin
                case (state)
                    WAIT_SOP: begin
                        if (startofpacket) begin
                            asm_pkt.dest_addr.hw_addr <= data;
                            bad   <= empty_bad;
                            state <= DEST1;
                        end else begin
                            error <= 1'b1;
                        end
                    end
                    DISCARD: begin
                        if (endofpacket)
                            state <= WAIT_SOP;
                    end
                    DATA2: begin
                        asm_pkt.data[95:64] <= data;
                        state <= endofpacket ? WAIT_SOP : DISCARD;
                        if (!endofpacket || bad || empty_bad) begin
                            error <= 1'b1;
                        end else begin
                            packet_data  <= commit_pkt;
                            packet_valid <= 1'b1;
                        end
                    end
                    default: begin
                        if (startofpacket) begin
                            // A stray SOP restarts assembly with this beat as the new header.
                            error <= 1'b1;
                            asm_pkt.dest_addr.hw_addr <= data;
                            bad   <= empty_bad;
                            state <= DEST1;
                        end else if (endofpacket) begin
                            error <= 1'b1;
                            state <= WAIT_SOP;
                        end else begin
                            bad   <= bad | empty_bad;
                            state <= state_t'(state + 4'd1);
                            case (state)
                                DEST1:   {asm_pkt.dest_addr.sw_addr, asm_pkt.dest_addr.port,
                                          asm_pkt.dest_addr.flag} <= data[31:8];
                                SRC0:    asm_pkt.src_addr.hw_addr <= data;
                                SRC1:    {asm_pkt.src_addr.sw_addr, asm_pkt.src_addr.port,
                                          asm_pkt.src_addr.flag} <= data[31:8];
                                LAMPORT: asm_pkt.lamport <= data;
                                DATA0:   asm_pkt.data[31:0] <= data;
                                DATA1:   asm_pkt.data[63:32] <= data;
                                default: asm_pkt.dest_addr.hw_addr <= data;
                            endcase
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_dircc_avalon_st_packet_receiver.sv
// tb_dircc_avalon_st_packet_receiver: directed bench with an expected-packet scoreboard
// for the DiRCC Avalon-ST packet receiver.
module tb_dircc_avalon_st_packet_receiver;
    import dircc_types_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] data = '0;
    logic [1:0]  empty = '0;
    logic        startofpacket = 1'b0;
    logic        endofpacket = 1'b0;
    logic        valid = 1'b0;
    logic        ready;
    logic        packet_valid;
    packet_t     packet_data;
    logic        packet_read = 1'b0;
    logic        receiving;
    logic        error;

    int checks = 0;
    int errors = 0;
    int err_cnt = 0;
    int rx_cnt = 0;
    logic pv_q = 1'b0;
    logic rd_q = 1'b0;
    packet_t q[$];

    dircc_avalon_st_packet_receiver dut (
        .clk(clk), .reset(reset), .data(data), .empty(empty),
        .startofpacket(startofpacket), .endofpacket(endofpacket), .valid(valid),
        .ready(ready), .packet_valid(packet_valid), .packet_data(packet_data),
        .packet_read(packet_read), .receiving(receiving), .error(error)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic packet_t mk(input logic [31:0] dhw, input logic [31:0] shw,
                                   input logic [31:0] lam, input logic [95:0] d,
                                   input logic [15:0] dsw, input logic [15:0] ssw);
        packet_t p;
        p.dest_addr = '{hw_addr: dhw, sw_addr: dsw, port: dsw[6:0] ^ 7'h55, flag: 1'b1};
        p.src_addr  = '{hw_addr: shw, sw_addr: ssw, port: ssw[6:0] ^ 7'h2a, flag: 1'b0};
        p.lamport   = lam;
        p.data      = d;
        return p;
    endfunction

    // DEST1/SRC1 low byte carries junk that the receiver must ignore.
    function automatic logic [31:0] beat_of(input packet_t p, input int i);
        case (i)
            0: return p.dest_addr.hw_addr;
            1: return {p.dest_addr.sw_addr, p.dest_addr.port, p.dest_addr.flag, 8'ha5};
            2: return p.src_addr.hw_addr;
            3: return {p.src_addr.sw_addr, p.src_addr.port, p.src_addr.flag, 8'h5a};
            4: return p.lamport;
            5: return p.data[31:0];
            6: return p.data[63:32];
            7: return p.data[95:64];
            default: return 32'h0;
        endcase
    endfunction

    task automatic beat(input logic [31:0] d, input logic s, input logic e,
                        input logic [1:0] em, input int max, output logic acc);
        data = d; startofpacket = s; endofpacket = e; empty = em; valid = 1'b1;
        acc = 1'b0;
        for (int i = 0; i < max && !acc; i++) begin
            @(negedge clk);
            acc = ready;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic put(input logic [31:0] d, input logic s, input logic e,
                       input logic [1:0] em, input int max);
        logic acc;
        beat(d, s, e, em, max, acc);
        chk("beat_accept", acc, 1'b1);
    endtask

    task automatic send_pkt(input packet_t p);
        for (int i = 0; i < 8; i++)
            put(beat_of(p, i), i == 0, i == 7, 2'd0, 1);
        valid = 1'b0;
    endtask

    task automatic idle(input int n);
        valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic read_pkt();
        packet_read = 1'b1;
        @(posedge clk);
        #1;
        packet_read = 1'b0;
    endtask

    // A new packet appears when packet_valid rises or stays high across a read.
    always @(negedge clk) begin
        if (error)
            err_cnt++;
        if (packet_valid && (!pv_q || rd_q)) begin
            chk("pkt_expected", q.size() != 0, 1'b1);
            if (q.size() != 0) begin
                chk("pkt_data", packet_data, q.pop_front());
                rx_cnt++;
            end
        end
        pv_q = packet_valid;
        rd_q = packet_read;
    end

    initial begin
        packet_t pa, pb, pc, pd, pe, pf, pg, ph, pj;
        logic acc;
        int e0;
        pa = mk(32'h0000_0012, 32'h0000_0034, 32'd5, {32'h3, 32'h2, 32'h1}, 16'h1111, 16'h2222);
        pb = mk(32'hb000_0001, 32'hb000_0002, 32'd17, 96'hbbbb_0000_1111_2222_3333_4444, 16'hb0b0, 16'h0b0b);
        pc = mk(32'hc000_0001, 32'hc000_0002, 32'd18, 96'hcccc_5555_6666_7777_8888_9999, 16'hc0c0, 16'h0c0c);
        pd = mk(32'hd000_0001, 32'hd000_0002, 32'd19, 96'hdddd_aaaa_bbbb_cccc_dddd_eeee, 16'hd0d0, 16'h0d0d);
        pe = mk(32'he000_0001, 32'he000_0002, 32'd20, 96'heeee_1234_5678_9abc_def0_1357, 16'he0e0, 16'h0e0e);
        pf = mk(32'hf000_0001, 32'hf000_0002, 32'd21, 96'hffff_2468_ace0_1357_9bdf_0000, 16'hf0f0, 16'h0f0f);
        pg = mk(32'h9000_0001, 32'h9000_0002, 32'd22, 96'h9999_8888_7777_6666_5555_4444, 16'h9090, 16'h0909);
        ph = mk(32'h8000_0001, 32'h8000_0002, 32'd23, 96'h8888_0123_4567_89ab_cdef_fedc, 16'h8080, 16'h0808);
        pj = mk(32'hdead_beef, 32'hbad0_bad0, 32'd99, 96'h0bad_0bad_0bad_0bad_0bad_0bad, 16'hffff, 16'heeee);

        repeat (2) @(posedge clk);
        #1;
        chk("reset_packet_valid", packet_valid, 1'b0);
        chk("reset_error", error, 1'b0);
        chk("reset_receiving", receiving, 1'b0);
        chk("reset_ready", ready, 1'b1);
        reset = 1'b0;

        // Single clean packet, valid held high for all 8 beats.
        e0 = err_cnt;
        q.push_back(pa);
        send_pkt(pa);
        chk("single_latency", packet_valid, 1'b1);
        chk("single_receiving_done", receiving, 1'b0);
        read_pkt();
        idle(2);
        chk("single_no_error", err_cnt - e0, 0);
        chk("single_cleared", packet_valid, 1'b0);

        // Back-pressure: buffer full, only the second packet's final beat stalls.
        q.push_back(pb);
        send_pkt(pb);
        q.push_back(pc);
        for (int i = 0; i < 7; i++)
            put(beat_of(pc, i), i == 0, 1'b0, 2'd0, 1);
        beat(beat_of(pc, 7), 1'b0, 1'b1, 2'd0, 3, acc);
        chk("bp_stall", acc, 1'b0);
        chk("bp_ready_low", ready, 1'b0);
        chk("bp_receiving", receiving, 1'b1);
        packet_read = 1'b1;
        @(negedge clk);
        chk("bp_ready_on_read", ready, 1'b1);
        @(posedge clk);
        #1;
        packet_read = 1'b0;
        valid = 1'b0;
        chk("bp_valid_held", packet_valid, 1'b1);
        idle(1);
        read_pkt();
        idle(2);
        chk("bp_no_error", err_cnt - e0, 0);

        // Early EOP on beat 4.
        e0 = err_cnt;
        for (int i = 0; i < 3; i++)
            put(beat_of(pj, i), i == 0, 1'b0, 2'd0, 1);
        put(beat_of(pj, 3), 1'b0, 1'b1, 2'd0, 1);
        idle(3);
        chk("early_eop_error", err_cnt - e0, 1);
        chk("early_eop_no_pkt", packet_valid, 1'b0);
        chk("early_eop_idle", receiving, 1'b0);
        q.push_back(pd);
        send_pkt(pd);
        read_pkt();

        // Missing EOP on beat 8, then three trailing beats swallowed by DISCARD.
        e0 = err_cnt;
        for (int i = 0; i < 8; i++)
            put(beat_of(pj, i), i == 0, 1'b0, 2'd0, 1);
        put(32'h1111_1111, 1'b0, 1'b0, 2'd0, 1);
        put(32'h2222_2222, 1'b1, 1'b0, 2'd0, 1);
        chk("discard_receiving", receiving, 1'b1);
        put(32'h3333_3333, 1'b0, 1'b1, 2'd0, 1);
        idle(3);
        chk("missing_eop_error", err_cnt - e0, 1);
        chk("missing_eop_no_pkt", packet_valid, 1'b0);
        chk("discard_done", receiving, 1'b0);
        q.push_back(pe);
        send_pkt(pe);
        read_pkt();

        // SOP on beat 3 restarts a packet that then completes.
        e0 = err_cnt;
        put(beat_of(pj, 0), 1'b1, 1'b0, 2'd0, 1);
        put(beat_of(pj, 1), 1'b0, 1'b0, 2'd0, 1);
        q.push_back(pf);
        send_pkt(pf);
        chk("sop_restart_valid", packet_valid, 1'b1);
        idle(2);
        chk("sop_restart_error", err_cnt - e0, 1);

        // Reset after beat 5 with pf still unread in the buffer.
        e0 = err_cnt;
        for (int i = 0; i < 5; i++)
            put(beat_of(pj, i), i == 0, 1'b0, 2'd0, 1);
        valid = 1'b0;
        chk("pre_reset_receiving", receiving, 1'b1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("reset_mid_pv", packet_valid, 1'b0);
        chk("reset_mid_receiving", receiving, 1'b0);
        chk("reset_mid_error", error, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        q.push_back(pg);
        send_pkt(pg);
        read_pkt();
        idle(2);
        chk("reset_no_error", err_cnt - e0, 0);

        // Nonzero empty taints the packet; the next packet starts clean.
        e0 = err_cnt;
        for (int i = 0; i < 8; i++)
            put(beat_of(pj, i), i == 0, i == 7, (i == 2) ? 2'd1 : 2'd0, 1);
        idle(3);
        chk("empty_error", err_cnt - e0, 1);
        chk("empty_no_pkt", packet_valid, 1'b0);
        q.push_back(ph);
        send_pkt(ph);
        read_pkt();
        idle(2);
        chk("empty_flag_cleared", err_cnt - e0, 1);

        // Beat without SOP while idle.
        e0 = err_cnt;
        put(32'h7777_7777, 1'b0, 1'b0, 2'd0, 1);
        idle(3);
        chk("stray_beat_error", err_cnt - e0, 1);
        chk("stray_beat_idle", receiving, 1'b0);

        chk("scoreboard_drained", q.size(), 0);
        chk("packets_received", rx_cnt, 8);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
